// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Control FSM for the multicycle datapath. It decodes the instruction register
// and the condition flags, then steps through the fetch, decode and execute
// states for ARM-style data-processing, LDR/STR and B/BL instructions.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high; forces FETCH
//   INSTRUCTION  IR contents from the datapath
//   FLAGS        {N,Z,C,V} from the datapath
//   A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src
//                1-bit datapath controls
//   ALUSrcA, ALUSrcB, ResultSrc, RegSrc  2-bit datapath mux selects
//   ALUop, ShiftType                     3-bit ALU and shifter controls
//   state        current state code, for debug
//   illegal      1-cycle pulse in DECODE when op=11
//
// Outputs are Moore: they are decoded from the registered state only. The IR
// operand fields they use are stable from DECODE onwards.
// ---------------------------------------------------------------------------
module multicycle_control_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] INSTRUCTION,
   input  logic [3:0]  FLAGS,
   output logic        A3Src,
   output logic        AdrSrc,
   output logic        FlagUpdate,
   output logic        IRWrite,
   output logic        MemWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic        WD3Src,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  RegSrc,
   output logic [2:0]  ALUop,
   output logic [2:0]  ShiftType,
   output logic [3:0]  state,
   output logic        illegal
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9
   } state_e;

   state_e state_q, state_d;

   // Instruction fields
   logic [3:0] cond;
   logic [1:0] op;
   logic       i_bit;
   logic [3:0] cmd;
   logic       s_bit;
   logic       link;
   logic [1:0] sh;

   assign cond  = INSTRUCTION[31:28];
   assign op    = INSTRUCTION[27:26];
   assign i_bit = INSTRUCTION[25];
   assign cmd   = INSTRUCTION[24:21];
   assign s_bit = INSTRUCTION[20];
   assign link  = INSTRUCTION[24];
   assign sh    = INSTRUCTION[6:5];

   // Register numbers and immediates are consumed by the datapath, not here.
   logic unused_instr;
   assign unused_instr = ^{INSTRUCTION[19:7], INSTRUCTION[4:0]};

   logic flag_n, flag_z, flag_c, flag_v;
   assign {flag_n, flag_z, flag_c, flag_v} = FLAGS;

   // Condition evaluation
   logic cond_pass;
   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = ~flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = ~flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = ~flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = ~flag_v;
         4'b1000: cond_pass = flag_c & ~flag_z;
         4'b1001: cond_pass = ~flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // ALU operation by cmd; 111 marks an unsupported cmd (executed as a NOP)
   logic [2:0] dp_aluop;
   logic       dp_supported;
   logic       is_cmp;
   always_comb begin
      dp_aluop = 3'b111;
      case (cmd)
         4'b0000: dp_aluop = 3'b100;
         4'b0010: dp_aluop = 3'b001;
         4'b0100: dp_aluop = 3'b000;
         4'b1010: dp_aluop = 3'b001;
         4'b1100: dp_aluop = 3'b101;
         4'b1101: dp_aluop = 3'b110;
         default: dp_aluop = 3'b111;
      endcase
   end

   assign dp_supported = (dp_aluop != 3'b111);
   assign is_cmp       = (cmd == 4'b1010);

   // Next-state logic
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch: state_d = StDecode;
         StDecode: begin
            if (!cond_pass || op == 2'b11) begin
               state_d = StFetch;
            end else begin
               case (op)
                  2'b01:   state_d = StMemAdr;
                  2'b10:   state_d = StBranch;
                  default: state_d = i_bit ? StExecI : StExecR;
               endcase
            end
         end
         StMemAdr:   state_d = s_bit ? StMemRead : StMemWrite;
         StMemRead:  state_d = StMemWb;
         StMemWb:    state_d = StFetch;
         StMemWrite: state_d = StFetch;
         StExecR,
         StExecI:    state_d = is_cmp ? StFetch : StAluWb;
         StAluWb:    state_d = StFetch;
         StBranch:   state_d = StFetch;
         default:    state_d = StFetch;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

   // Moore output decode
   always_comb begin
      A3Src      = 1'b0;
      AdrSrc     = 1'b0;
      FlagUpdate = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      WD3Src     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      RegSrc     = 2'b00;
      ALUop      = 3'b000;
      ShiftType  = 3'b111;
      illegal    = 1'b0;
      case (state_q)
         StFetch: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = 2'b11;
            ResultSrc = 2'b10;
            RegSrc    = 2'b10;
         end
         StDecode: begin
            ResultSrc = 2'b10;
            RegSrc    = {op == 2'b01, op == 2'b10};
            illegal   = (op == 2'b11);
         end
         StMemAdr: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            RegSrc  = 2'b10;
         end
         StMemRead: begin
            AdrSrc  = 1'b1;
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            RegSrc  = 2'b10;
         end
         StMemWb: begin
            AdrSrc    = 1'b1;
            RegWrite  = 1'b1;
            ResultSrc = 2'b01;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b01;
            RegSrc    = 2'b10;
         end
         StMemWrite: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            RegSrc   = 2'b10;
         end
         StExecR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b00;
            ShiftType  = {1'b0, sh};
            ALUop      = dp_aluop;
            FlagUpdate = s_bit | is_cmp;
         end
         StExecI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUop      = dp_aluop;
            FlagUpdate = s_bit | is_cmp;
         end
         StAluWb: begin
            RegWrite  = dp_supported;
            ALUSrcA   = 2'b01;
            ResultSrc = 2'b00;
         end
         StBranch: begin
            PCWrite   = 1'b1;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            RegSrc    = 2'b01;
            // BL: LR <- PC+4
            RegWrite  = link;
            A3Src     = link;
            WD3Src    = link;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Scoreboard bench: each issued instruction pushes its expected per-cycle
// control vectors; a negedge monitor pops and compares one vector per cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

   logic        clock;
   logic        reset;
   logic [31:0] INSTRUCTION;
   logic [3:0]  FLAGS;
   logic        A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src;
   logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
   logic [2:0]  ALUop, ShiftType;
   logic [3:0]  state;
   logic        illegal;

   multicycle_control_unit dut (
      .clock       (clock),
      .reset       (reset),
      .INSTRUCTION (INSTRUCTION),
      .FLAGS       (FLAGS),
      .A3Src       (A3Src),
      .AdrSrc      (AdrSrc),
      .FlagUpdate  (FlagUpdate),
      .IRWrite     (IRWrite),
      .MemWrite    (MemWrite),
      .PCWrite     (PCWrite),
      .RegWrite    (RegWrite),
      .WD3Src      (WD3Src),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ResultSrc   (ResultSrc),
      .RegSrc      (RegSrc),
      .ALUop       (ALUop),
      .ShiftType   (ShiftType),
      .state       (state),
      .illegal     (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {state, illegal, A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite,
   //  WD3Src, ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType}
   logic [26:0] act_vec;
   assign act_vec = {state, illegal, A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite,
                     RegWrite, WD3Src, ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType};

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   int ill_seen = 0;
   int ill_exp = 0;
   logic mon_en = 1'b0;
   logic [26:0] sb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, b;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0:    b = z;
         3'd1:    b = cf;
         3'd2:    b = n;
         3'd3:    b = v;
         3'd4:    b = cf && !z;
         3'd5:    b = (n == v);
         3'd6:    b = !z && (n == v);
         default: b = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? !b : b;
   endfunction

   function automatic logic [2:0] alu_code(input logic [3:0] c);
      case (c)
         4'b0000: return 3'b100;  // AND
         4'b0010: return 3'b001;  // SUB
         4'b0100: return 3'b000;  // ADD
         4'b1010: return 3'b001;  // CMP
         4'b1100: return 3'b101;  // ORR
         4'b1101: return 3'b110;  // MOV
         default: return 3'b111;
      endcase
   endfunction

   // Expected control vector for a named step of the instruction flow
   function automatic logic [26:0] exp_vec(input logic [3:0] code, input logic [31:0] ir);
      logic il, a3, adr, fu, irw, mw, pcw, rw, wd3;
      logic [1:0] sa, sb_, rs, rg;
      logic [2:0] alu, sht;
      {il, a3, adr, fu, irw, mw, pcw, rw, wd3} = '0;
      {sa, sb_, rs, rg} = '0;
      alu = 3'b000;
      sht = 3'b111;
      case (code)
         4'd0: begin irw = 1; pcw = 1; sb_ = 2'b11; rs = 2'b10; rg = 2'b10; end
         4'd1: begin
            rs = 2'b10;
            rg = {ir[27:26] == 2'b01, ir[27:26] == 2'b10};
            il = (ir[27:26] == 2'b11);
         end
         4'd2: begin sa = 2'b01; sb_ = 2'b01; rg = 2'b10; end
         4'd3: begin adr = 1; sa = 2'b01; sb_ = 2'b01; rg = 2'b10; end
         4'd4: begin adr = 1; rw = 1; rs = 2'b01; sa = 2'b01; sb_ = 2'b01; rg = 2'b10; end
         4'd5: begin adr = 1; mw = 1; rg = 2'b10; end
         4'd6, 4'd7: begin
            sa  = 2'b10;
            sb_ = (code == 4'd7) ? 2'b01 : 2'b00;
            if (code == 4'd6) sht = {1'b0, ir[6:5]};
            alu = alu_code(ir[24:21]);
            fu  = ir[20] || (ir[24:21] == 4'b1010);
         end
         4'd8: begin rw = (alu_code(ir[24:21]) != 3'b111); sa = 2'b01; end
         4'd9: begin
            pcw = 1; sa = 2'b01; sb_ = 2'b10; rs = 2'b10; rg = 2'b01;
            rw = ir[24]; a3 = ir[24]; wd3 = ir[24];
         end
         default: begin end
      endcase
      return {code, il, a3, adr, fu, irw, mw, pcw, rw, wd3, sa, sb_, rs, rg, alu, sht};
   endfunction

   // Push the full step sequence (FETCH .. last state) of one instruction
   task automatic expect_instr(input logic [31:0] ir, input logic [3:0] fl, output int n);
      logic [3:0] seq[$];
      logic [1:0] op;
      op = ir[27:26];
      seq.push_back(4'd0);
      seq.push_back(4'd1);
      if (op == 2'b11) ill_exp++;
      if (op != 2'b11 && cond_ok(ir[31:28], fl)) begin
         case (op)
            2'b01: begin
               seq.push_back(4'd2);
               if (ir[20]) begin seq.push_back(4'd3); seq.push_back(4'd4); end
               else seq.push_back(4'd5);
            end
            2'b10: seq.push_back(4'd9);
            default: begin
               seq.push_back(ir[25] ? 4'd7 : 4'd6);
               if (ir[24:21] != 4'b1010) seq.push_back(4'd8);
            end
         endcase
      end
      foreach (seq[i]) sb.push_back(exp_vec(seq[i], ir));
      n = seq.size();
   endtask

   // Entered 1 time unit after the edge that starts a FETCH cycle; the IR load
   // is mimicked by switching INSTRUCTION at the FETCH->DECODE edge.
   task automatic run_instr(input logic [31:0] ir, input logic [3:0] fl);
      int n;
      expect_instr(ir, fl, n);
      @(posedge clock); #1;
      INSTRUCTION = ir;
      FLAGS = fl;
      repeat (n - 1) begin @(posedge clock); #1; end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      if (mon_en) begin
         cycle++;
         if (illegal) ill_seen++;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard underflow: cycle %0d got %h, expected none", cycle,
                     act_vec);
         end else begin
            check($sformatf("cycle %0d vector", cycle), {5'd0, act_vec}, {5'd0, sb.pop_front()});
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] rir;
   logic [3:0]  cmds[6];
   int          ill_before;

   initial begin
      cmds = '{4'b0000, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1101};
      reset = 1'b1;
      INSTRUCTION = 32'h0;
      FLAGS = 4'h0;
      #3;
      check("reset vector", {5'd0, act_vec}, {5'd0, exp_vec(4'd0, 32'h0)});
      @(posedge clock); #1;
      reset = 1'b0;
      mon_en = 1'b1;

      run_instr(32'hE5911040, 4'h0);   // LDR
      run_instr(32'hE0010002, 4'h0);   // AND R0,R1,R2
      run_instr(32'h00810002, 4'h0);   // ADDEQ, Z=0: skipped
      run_instr(32'h00810002, 4'h4);   // ADDEQ, Z=1: executes
      run_instr(32'hEB000010, 4'h0);   // BL
      run_instr(32'hEA000010, 4'h0);   // B
      run_instr(32'hE5812041, 4'h0);   // STR
      run_instr(32'hE1510002, 4'h0);   // CMP
      ill_before = ill_seen;
      run_instr(32'hEC000000, 4'h0);   // op=11
      check("illegal pulse count", 32'(ill_seen - ill_before), 32'd1);

      // Reset asserted off-edge while in MEMREAD
      sb.push_back(exp_vec(4'd0, 32'hE5911040));
      sb.push_back(exp_vec(4'd1, 32'hE5911040));
      sb.push_back(exp_vec(4'd2, 32'hE5911040));
      sb.push_back(exp_vec(4'd0, 32'hE5911040));
      @(posedge clock); #1;
      INSTRUCTION = 32'hE5911040;
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("state before reset", {28'd0, state}, 32'd3);
      #1 reset = 1'b1;
      #1;
      check("state in async reset", {28'd0, state}, 32'd0);
      check("IRWrite in async reset", {31'd0, IRWrite}, 32'd1);
      @(posedge clock); #1;
      reset = 1'b0;

      // Randomized instruction mix
      for (int k = 0; k < 200; k++) begin
         rir = $urandom();
         if ($urandom_range(0, 1) == 0) rir[31:28] = 4'hE;
         case ($urandom_range(0, 9))
            0, 1, 2, 3: rir[27:26] = 2'b00;
            4, 5:       rir[27:26] = 2'b01;
            6, 7:       rir[27:26] = 2'b10;
            8:          rir[27:26] = 2'b11;
            default:    begin end
         endcase
         if (rir[27:26] == 2'b00 && $urandom_range(0, 3) != 0)
            rir[24:21] = cmds[$urandom_range(0, 5)];
         run_instr(rir, 4'($urandom_range(0, 15)));
      end

      mon_en = 1'b0;
      check("scoreboard drained", 32'(sb.size()), 32'd0);
      check("total illegal pulses", 32'(ill_seen), 32'(ill_exp));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
